// File: rtl/handshake_master_fifo.sv
`default_nettype none
// ============================================================================
// Module      : handshake_master_fifo
// Description : Valid/ready source. Producer words are buffered in a
//               DEPTH-entry register FIFO and presented on a handshake output
//               whose valid/data are held stable until the sink accepts them.
//               Optional stall watchdog compiled in with the macro
//               HANDSHAKE_TIMEOUT_EN; without it, timeout is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module handshake_master_fifo #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     timeout
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = c_ADDR_W + 1;

    localparam logic [c_ADDR_W-1:0] c_PTR_ONE  = c_ADDR_W'(1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]  c_CNT_FULL = c_CNT_W'(DEPTH);

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    logic w_push;
    logic w_pop;

    // Status flags come straight from the registered count, so none of them
    // (out_valid in particular) has a combinational path from out_ready.
    assign full      = (r_count == c_CNT_FULL);
    assign empty     = (r_count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = r_count;

    // Head word is a plain register read: stable while the sink stalls.
    assign out_data  = r_mem[r_rd_ptr];

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // Storage array; cleared on reset so out_data reads 0 afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Write pointer advances on every accepted word, wrapping modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
        end
    end

    // Read pointer advances on every completed output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef HANDSHAKE_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [c_TO_W-1:0] c_TO_MAX = c_TO_W'(TIMEOUT_CYC);
    localparam logic [c_TO_W-1:0] c_TO_ONE = c_TO_W'(1);

    logic [c_TO_W-1:0] r_stall_cnt;
    logic              r_timeout;
    logic              w_stall;

    // A stall is a presented word the sink refuses this cycle.
    assign w_stall = out_valid && !out_ready;

    // Consecutive stall cycles, saturating at the threshold; any pop or an
    // idle output restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (!w_stall) begin
            r_stall_cnt <= '0;
        end else if (r_stall_cnt != c_TO_MAX) begin
            r_stall_cnt <= r_stall_cnt + c_TO_ONE;
        end
    end

    // Sticky flag, raised on the edge where the stall count hits the threshold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else if (w_stall && ((r_stall_cnt + c_TO_ONE) == c_TO_MAX)) begin
            r_timeout <= 1'b1;
        end
    end

    assign timeout = r_timeout;
`else
    // Watchdog not built; the threshold parameter has no effect here.
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYC > 0);
    assign timeout              = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_handshake_master_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_handshake_master_fifo
// Description : Self-checking bench for handshake_master_fifo: directed
//               vector table, hand-written corner sequences and a randomized
//               run compared against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_handshake_master_fifo;

    localparam int DATA_W      = 8;
    localparam int DEPTH       = 4;
    localparam int TIMEOUT_CYC = 5;
`ifdef HANDSHAKE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        count;
    logic              empty;
    logic              full;
    logic              timeout;

    handshake_master_fifo #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: ordered contents, run length of stalls, sticky flag.
    logic [DATA_W-1:0] q[$];
    int                stall_run = 0;
    bit                to_flag   = 1'b0;

    typedef struct packed {
        logic              iv;
        logic [DATA_W-1:0] d;
        logic              ordy;
        logic              e_ir;
        logic              e_ov;
        logic              e_chkd;
        logic [DATA_W-1:0] e_od;
        logic [2:0]        e_cnt;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model.
    task automatic step(input logic iv, input logic [DATA_W-1:0] d, input logic ordy);
        bit do_push;
        bit do_pop;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        do_push = iv && (q.size() < DEPTH);
        do_pop  = (q.size() > 0) && ordy;
        if ((q.size() > 0) && !ordy) begin
            if (stall_run < TIMEOUT_CYC) stall_run++;
        end else begin
            stall_run = 0;
        end
        if (stall_run >= TIMEOUT_CYC) to_flag = 1'b1;
        @(posedge clk);
        if (do_pop)  q.delete(0);
        if (do_push) q.push_back(d);
        #1;
    endtask

    task automatic check_model(input string tag);
        int n;
        n = q.size();
        check({tag, "_count"},     32'(count),     32'(n));
        check({tag, "_out_valid"}, 32'(out_valid), 32'(n > 0));
        check({tag, "_in_ready"},  32'(in_ready),  32'(n < DEPTH));
        check({tag, "_full"},      32'(full),      32'(n == DEPTH));
        check({tag, "_empty"},     32'(empty),     32'(n == 0));
        check({tag, "_timeout"},   32'(timeout),   32'(TO_EN && to_flag));
        if (n > 0) check({tag, "_out_data"}, 32'(out_data), 32'(q[0]));
    endtask

    initial begin
        int pop_idx;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Push 00/11/22 straight through, then fill to full, overflow
        // attempt, full+pop, refill, drain.
        tbl[0]  = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 3'd1};
        tbl[1]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 3'd1};
        tbl[2]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 3'd1};
        tbl[3]  = '{1'b0, 8'h99, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0};
        tbl[4]  = '{1'b1, 8'hA0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA0, 3'd1};
        tbl[5]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA0, 3'd2};
        tbl[6]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA0, 3'd3};
        tbl[7]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 3'd4};
        tbl[8]  = '{1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 3'd4};
        tbl[9]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA1, 3'd3};
        tbl[10] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd4};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA2, 3'd3};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA3, 3'd2};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 3'd1};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_count",     32'(count),     32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_empty",     32'(empty),     32'd1);
        check("rst_full",      32'(full),      32'd0);
        check("rst_timeout",   32'(timeout),   32'd0);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].iv, tbl[i].d, tbl[i].ordy);
            check($sformatf("tbl%0d_count", i),     32'(count),     32'(tbl[i].e_cnt));
            check($sformatf("tbl%0d_in_ready", i),  32'(in_ready),  32'(tbl[i].e_ir));
            check($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            check($sformatf("tbl%0d_full", i),      32'(full),      32'(tbl[i].e_cnt == 3'd4));
            check($sformatf("tbl%0d_empty", i),     32'(empty),     32'(tbl[i].e_cnt == 3'd0));
            if (tbl[i].e_chkd)
                check($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_od));
        end

        // Stall: one word held for 10 cycles, watchdog threshold 5.
        step(1'b1, 8'h5C, 1'b0);
        check_model("stall_load");
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 8'(k), 1'b0);
            check($sformatf("stall%0d_out_data", k),  32'(out_data),  32'h5C);
            check($sformatf("stall%0d_out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("stall%0d_timeout", k),   32'(timeout),   32'(TO_EN && (k >= TIMEOUT_CYC)));
        end
        step(1'b0, 8'h00, 1'b1);
        check_model("stall_pop");
        check("stall_timeout_sticky", 32'(timeout), 32'(TO_EN));

        // Six words across the pointer wrap, order preserved.
        pop_idx = 0;
        for (int i = 0; i < 9; i++) begin
            if (out_valid && (i >= 3)) begin
                check($sformatf("wrap_pop%0d", pop_idx), 32'(out_data), 32'(8'hC0 + pop_idx));
                pop_idx++;
            end
            step(i < 6, 8'(8'hC0 + i), i >= 3);
            check_model($sformatf("wrap%0d", i));
        end
        check("wrap_pop_total", 32'(pop_idx), 32'd6);

        // Asynchronous reset between edges with three words stored.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hD0 + i), 1'b0);
        check("prerst_count", 32'(count), 32'd3);
        #3;
        rst = 1'b1;
        #1;
        check("arst_count",     32'(count),     32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data",  32'(out_data),  32'd0);
        check("arst_in_ready",  32'(in_ready),  32'd1);
        check("arst_empty",     32'(empty),     32'd1);
        check("arst_timeout",   32'(timeout),   32'd0);
        q.delete();
        stall_run = 0;
        to_flag   = 1'b0;
        #2;
        rst = 1'b0;

        // Randomized traffic against the model; first half sink-starved.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom),
                 $urandom_range(0, 99) < ((i < 200) ? 30 : 75));
            check_model($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
